sr_pulse_gen: RTL

Debounces two raw push-button inputs (set and clear) and converts each debounced press into a single-cycle command pulse that drives the set/reset/enable inputs of the downstream `sr_latch`. Each channel runs a small debounce state machine, so mechanical bounce cannot cause repeated or spurious latch updates. A simultaneous press on both channels is suppressed and flagged, so the latch never sees a set and a reset in the same cycle.

---
 rtl/sr_pulse_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen: debounces raw set/clear push-buttons and turns each accepted
// press into a single-cycle command pulse for a downstream sr_latch.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous, active-high reset
//   set_btn   - raw set button (may bounce)
//   clr_btn   - raw clear button (may bounce)
//   s         - one-cycle set pulse (registered)
//   r         - one-cycle clear pulse (registered)
//   enable    - high exactly when s or r is high (registered)
//   conflict  - one-cycle flag when both presses are accepted together (registered)
//
// Configuration macro:
//   SR_PULSE_SYNC_EN - when defined, each raw input passes through a 2-flop
//                      synchronizer before its debounce FSM (adds 2 cycles).
//
// Parameters: DEBOUNCE_CYCLES >= 2, and 2**CNT_W > DEBOUNCE_CYCLES.

module sr_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic set_btn,
    input  logic clr_btn,
    output logic s,
    output logic r,
    output logic enable,
    output logic conflict
);

    localparam int unsigned NUM_CH = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } state_e;

    // Channel 0 is set, channel 1 is clear.
    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] smp;

    assign raw = {clr_btn, set_btn};

`ifdef SR_PULSE_SYNC_EN
    // Two-flop synchronizer per channel.
    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    assign smp = sync2_q;
`else
    assign smp = raw;
`endif

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] press_c;

    // Debounce FSM state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Debounce FSM next-state; press fires only on ARMING -> HELD.
    always_comb begin
        press_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (smp[i]) begin
                        state_d[i] = ARMING;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                ARMING: begin
                    if (!smp[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                        press_c[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!smp[i]) begin
                        state_d[i] = RELEASING;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                RELEASING: begin
                    if (smp[i]) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Registered command outputs; simultaneous presses are suppressed and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            s        <= 1'b0;
            r        <= 1'b0;
            enable   <= 1'b0;
            conflict <= 1'b0;
        end else begin
            s        <= press_c[0] & ~press_c[1];
            r        <= press_c[1] & ~press_c[0];
            enable   <= press_c[0] ^ press_c[1];
            conflict <= press_c[0] & press_c[1];
        end
    end

endmodule
